// File: rtl/fsm_pkg.sv
// Shared definitions for the serial-bit FSM library: state encoding,
// detection mode codes and the run qualification rule.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN0 = 2'b01,
        RUN1 = 2'b10
    } state_t;

    localparam logic [1:0] MODE_BOTH = 2'b00;
    localparam logic [1:0] MODE_ZERO = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // A run counts toward detection only if its polarity is enabled by mode.
    function automatic logic qualifies(input state_t s, input logic [1:0] m);
        return ((s == RUN0) && ((m == MODE_BOTH) || (m == MODE_ZERO))) ||
               ((s == RUN1) && ((m == MODE_BOTH) || (m == MODE_ONE)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-1. The next value is
// exported so the parent can register outputs derived from it.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic [W-1:0] next
);

    // Clear wins over load, load wins over increment; increment stops at all-ones.
    always_comb begin
        next = q;
        if (clear) begin
            next = '0;
        end else if (load1) begin
            next = W'(1);
        end else if (inc && (q != {W{1'b1}})) begin
            next = q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        q <= next;
    end

endmodule

// File: rtl/run_detector.sv
// Moore run-length detector: flags when the last RUN_LEN sampled bits are
// equal, filtered by a runtime polarity mode. There is no handshake: en acts
// as a per-cycle sample strobe, in is consumed on every edge with en=1 and
// the block never stalls its source.
module run_detector
    import fsm_pkg::*;
#(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    input  logic             in,
    input  logic [1:0]       mode,
    output logic             out,
    output logic             hit,
    output logic             run_val,
    output logic [CNT_W-1:0] run_cnt,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] THRESH     = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] THRESH_M1  = CNT_W'(RUN_LEN - 1);

    state_t             state_q;
    state_t             state_d;
    logic               cnt_clear;
    logic               cnt_load;
    logic               cnt_inc;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               out_d;
    logic               hit_d;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .clear (cnt_clear),
        .load1 (cnt_load),
        .inc   (cnt_inc),
        .q     (cnt_q),
        .next  (cnt_d)
    );

    // Next-state and counter control; illegal encodings fall back to IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        if (RESET) begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d  = in ? RUN1 : RUN0;
                        cnt_load = 1'b1;
                    end
                end
                RUN0: begin
                    if (en) begin
                        if (in) begin
                            state_d  = RUN1;
                            cnt_load = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                RUN1: begin
                    if (en) begin
                        if (!in) begin
                            state_d  = RUN0;
                            cnt_load = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // Output values from next state; hit needs an actual step onto threshold,
    // so a mode change on a long run raises out without hit.
    always_comb begin
        out_d = qualifies(state_d, mode) && (cnt_d >= THRESH);
        hit_d = cnt_inc && (cnt_q == THRESH_M1) && qualifies(state_d, mode);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        out     <= out_d;
        hit     <= hit_d;
        run_val <= (state_d == RUN1);
    end

    assign run_cnt   = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector: two instances (RUN_LEN=3/CNT_W=4 and
// RUN_LEN=5/CNT_W=3) share the stimulus; each scenario task checks inline.
module tb_run_detector;
    import fsm_pkg::*;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       en = 1'b0;
    logic       in_b = 1'b0;
    logic [1:0] mode = MODE_BOTH;

    logic       a_out, a_hit, a_val;
    logic [3:0] a_cnt;
    state_t     a_state;
    logic       b_out, b_hit, b_val;
    logic [2:0] b_cnt;
    state_t     b_state;

    int total = 0;
    int bad = 0;

    run_detector #(.RUN_LEN(3), .CNT_W(4)) dut_a (
        .clk(clk), .RESET(RESET), .en(en), .in(in_b), .mode(mode),
        .out(a_out), .hit(a_hit), .run_val(a_val), .run_cnt(a_cnt),
        .dbg_state(a_state)
    );

    run_detector #(.RUN_LEN(5), .CNT_W(3)) dut_b (
        .clk(clk), .RESET(RESET), .en(en), .in(in_b), .mode(mode),
        .out(b_out), .hit(b_hit), .run_val(b_val), .run_cnt(b_cnt),
        .dbg_state(b_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Apply one cycle of inputs and sample 1 time unit after the edge.
    task automatic step(input logic e, input logic b);
        en   = e;
        in_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (a_state !== IDLE) begin
            bad++; $display("FAIL reset_state got=%0d exp=%0d", a_state, IDLE);
        end
        total++;
        if ({a_out, a_hit, a_val, a_cnt} !== 7'd0) begin
            bad++; $display("FAIL reset_outs_a got=%b exp=0", {a_out, a_hit, a_val, a_cnt});
        end
        total++;
        if ({b_out, b_hit, b_val, b_cnt} !== 6'd0) begin
            bad++; $display("FAIL reset_outs_b got=%b exp=0", {b_out, b_hit, b_val, b_cnt});
        end
    endtask

    task automatic test_basic();
        logic       bits[5]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_out[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       exp_hit[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp_cnt[5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
        do_reset();
        mode = MODE_BOTH;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bits[i]);
            total++;
            if (a_out !== exp_out[i]) begin
                bad++; $display("FAIL basic_out[%0d] got=%b exp=%b", i, a_out, exp_out[i]);
            end
            total++;
            if (a_hit !== exp_hit[i]) begin
                bad++; $display("FAIL basic_hit[%0d] got=%b exp=%b", i, a_hit, exp_hit[i]);
            end
            total++;
            if (a_cnt !== exp_cnt[i]) begin
                bad++; $display("FAIL basic_cnt[%0d] got=%0d exp=%0d", i, a_cnt, exp_cnt[i]);
            end
        end
        total++;
        if (a_val !== 1'b1 || a_state !== RUN1) begin
            bad++; $display("FAIL basic_flip got val=%b state=%0d exp val=1 state=%0d", a_val, a_state, RUN1);
        end
    endtask

    task automatic test_zero_only();
        do_reset();
        mode = MODE_ZERO;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            total++;
            if (a_out !== 1'b0 || a_hit !== 1'b0) begin
                bad++; $display("FAIL zero_only_flags[%0d] got out=%b hit=%b exp 0 0", i, a_out, a_hit);
            end
        end
        total++;
        if (a_val !== 1'b1 || a_cnt !== 4'd4) begin
            bad++; $display("FAIL zero_only_run got val=%b cnt=%0d exp val=1 cnt=4", a_val, a_cnt);
        end
    endtask

    task automatic test_mode_off();
        do_reset();
        mode = MODE_OFF;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            total++;
            if (a_out !== 1'b0 || a_hit !== 1'b0) begin
                bad++; $display("FAIL mode_off[%0d] got out=%b hit=%b exp 0 0", i, a_out, a_hit);
            end
        end
    endtask

    task automatic test_saturate();
        logic [2:0] ec;
        do_reset();
        mode = MODE_ONE;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1);
            ec = (i > 7) ? 3'd7 : 3'(i);
            total++;
            if (b_hit !== (i == 5)) begin
                bad++; $display("FAIL sat_hit[bit%0d] got=%b exp=%b", i, b_hit, (i == 5));
            end
            total++;
            if (b_out !== (i >= 5)) begin
                bad++; $display("FAIL sat_out[bit%0d] got=%b exp=%b", i, b_out, (i >= 5));
            end
            total++;
            if (b_cnt !== ec) begin
                bad++; $display("FAIL sat_cnt[bit%0d] got=%0d exp=%0d", i, b_cnt, ec);
            end
        end
    endtask

    task automatic test_enable_hold();
        do_reset();
        mode = MODE_BOTH;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, i[0]);
            total++;
            if (a_cnt !== 4'd2 || a_out !== 1'b0 || a_hit !== 1'b0) begin
                bad++; $display("FAIL hold[%0d] got cnt=%0d out=%b hit=%b exp 2 0 0", i, a_cnt, a_out, a_hit);
            end
        end
        step(1'b1, 1'b0);
        total++;
        if (a_cnt !== 4'd3 || a_out !== 1'b1 || a_hit !== 1'b1) begin
            bad++; $display("FAIL hold_resume got cnt=%0d out=%b hit=%b exp 3 1 1", a_cnt, a_out, a_hit);
        end
        step(1'b0, 1'b0);
        total++;
        if (a_out !== 1'b1 || a_hit !== 1'b0) begin
            bad++; $display("FAIL hold_hit_clear got out=%b hit=%b exp 1 0", a_out, a_hit);
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode = MODE_ONE;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            total++;
            if (a_out !== 1'b0 || a_hit !== 1'b0) begin
                bad++; $display("FAIL switch_pre[%0d] got out=%b hit=%b exp 0 0", i, a_out, a_hit);
            end
        end
        mode = MODE_ZERO;
        step(1'b0, 1'b0);
        total++;
        if (a_out !== 1'b1 || a_hit !== 1'b0 || a_cnt !== 4'd4) begin
            bad++; $display("FAIL switch_post got out=%b hit=%b cnt=%0d exp 1 0 4", a_out, a_hit, a_cnt);
        end
        step(1'b1, 1'b0);
        total++;
        if (a_out !== 1'b1 || a_hit !== 1'b0 || a_cnt !== 4'd5) begin
            bad++; $display("FAIL switch_next got out=%b hit=%b cnt=%0d exp 1 0 5", a_out, a_hit, a_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        mode = MODE_BOTH;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        RESET = 1'b1;
        step(1'b1, 1'b0);
        total++;
        if ({a_out, a_hit, a_val, a_cnt} !== 7'd0 || a_state !== IDLE) begin
            bad++; $display("FAIL midreset got outs=%b state=%0d exp 0 IDLE", {a_out, a_hit, a_val, a_cnt}, a_state);
        end
        RESET = 1'b0;
        step(1'b1, 1'b0);
        total++;
        if (a_cnt !== 4'd1 || a_out !== 1'b0) begin
            bad++; $display("FAIL midreset_r1 got cnt=%0d out=%b exp 1 0", a_cnt, a_out);
        end
        step(1'b1, 1'b0);
        total++;
        if (a_cnt !== 4'd2 || a_out !== 1'b0 || a_hit !== 1'b0) begin
            bad++; $display("FAIL midreset_r2 got cnt=%0d out=%b hit=%b exp 2 0 0", a_cnt, a_out, a_hit);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_only();
        test_mode_off();
        test_saturate();
        test_enable_hold();
        test_mode_switch();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised Moore run-length detector for a serial bit stream. It flags when the last `RUN_LEN` sampled bits are all equal, with a runtime mode that selects zero-runs, one-runs, or both. It also reports the value and saturating length of the current run, and pulses once when a qualifying run first reaches threshold. It generalises the fixed 3-bit zero/one run detector and sits in the same FSM library, fed by a bit-serial front end.

## Interface
- `RUN_LEN`, default 3: run length at which `out` asserts; legal range 2..2^CNT_W-1.
- `CNT_W`, default 4: width of the run-length counter.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `en` input 1: sample enable; `in` is consumed only on edges where `en`=1.
- `in` input 1: serial data bit.
- `mode` input 2: 2'b00 both polarities, 2'b01 zero-runs only, 2'b10 one-runs only, 2'b11 detection off.
- `out` output 1: level; a qualifying run of length >= `RUN_LEN` is in progress.
- `hit` output 1: one-cycle pulse on the edge where a qualifying run first reaches `RUN_LEN`.
- `run_val` output 1: bit value of the current run (0 in IDLE).
- `run_cnt` output CNT_W: current run length, saturating at 2^CNT_W-1.

## Operation
- FSM states:
  - IDLE: no bit sampled since reset.
  - RUN0: current run is of zeros.
  - RUN1: current run is of ones.
- All outputs are registered. Each is computed from next-state values and `mode` at the sampling edge, so it is a pure function of the registered state.
- Transitions, on an edge with `en`=1:
  - From IDLE, `in`=0 goes to RUN0 and `in`=1 goes to RUN1, with cnt=1.
  - In RUN0, `in`=0 stays and increments cnt.
  - In RUN0, `in`=1 goes to RUN1 with cnt=1.
  - RUN1 behaves symmetrically.
- cnt saturates at 2^CNT_W-1 and never wraps. `out` stays high through saturation.
- qualify = (RUN0 and mode in {00,01}) or (RUN1 and mode in {00,10}).
- `out` = qualify and cnt >= `RUN_LEN`.
- `hit` = qualify and cnt was incremented to exactly `RUN_LEN` on this edge. It is 0 on every other edge, including edges with `en`=0.
- `en`=0: state, cnt, `run_val`, `run_cnt` and `out` hold. `out` is re-evaluated against the current `mode`, so a mode change with `en`=0 takes effect on the next edge. `hit` is forced to 0.
- Mode change mid-run: cnt is unaffected; only `out` and `hit` qualification change.
- Mode change alone never generates `hit`: a run already at >= `RUN_LEN` becoming qualified raises `out` without `hit`.
- Illegal state encoding recovers to IDLE with all outputs 0 on the next edge.

## Timing
- Latency: the edge that samples the `RUN_LEN`-th equal bit makes `out` high (and `hit` high, if qualified) immediately after that edge. This matches the Moore behaviour of the fixed 3-bit detector.
- Polarity change: `in` flipping drops `out` immediately after the sampling edge; cnt becomes 1.
- `RESET`=1 at an edge takes priority over `en`:
  - state IDLE;
  - `out`=0, `hit`=0, `run_val`=0, `run_cnt`=0.
- `RESET` mid-run discards the run. The first bit after release starts at cnt=1.
- Throughput: one bit per cycle. No back-pressure.

## Structure
- Shared package `fsm_pkg`:
  - state encoding constants IDLE=2'b00, RUN0=2'b01, RUN1=2'b10;
  - mode codes MODE_BOTH, MODE_ZERO, MODE_ONE, MODE_OFF.
- Sub-module `sat_counter` (parameter W): synchronous clear, load-1, increment-with-saturation; instantiated once for cnt.
- Top level: state register, next-state logic, qualify/out/hit output registers.

## Test plan
- RUN_LEN=3, mode=00, `en`=1, `in`=0,0,0,0,1 -> `out`=0,0,1,1,0; `hit`=0,0,1,0,0; `run_cnt`=1,2,3,4,1.
- RUN_LEN=3, mode=01, `in`=1,1,1,1 -> `out` stays 0, `hit` stays 0; `run_val`=1, `run_cnt`=4.
- RUN_LEN=5, CNT_W=3, 12 consecutive 1s, mode=10 -> `hit` only on bit 5; `out` high from bit 5; `run_cnt` saturates at 7 and holds.
- `in`=0,0 then `en`=0 for 4 cycles, then `in`=0 with `en`=1 (RUN_LEN=3) -> `run_cnt` holds 2 while `en`=0; `out` and `hit` rise on the third enabled sample.
- Run of 4 zeros under mode=10, then mode switched to 01 with `en`=0 -> `out` rises on the next edge and `hit` stays 0.
- `RESET` asserted after 2 zeros, released, then `in`=0,0 -> `out` stays 0; all outputs 0 during reset; `run_cnt`=1,2 after release.
